// File: rtl/dmem_requester.sv
// Pipeline-side initiator for the slow data RAM: holds one load/store stable until mem_ack.
// Optional timeout abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  output logic                  cpu_stall,
  output logic                  cpu_valid,
  output logic                  cpu_err,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic       we_r;
  logic       timeout;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_r;

  // wait_cnt holds the number of BUSY cycles already spent, so the limit is hit on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == BUSY) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout = (state == BUSY) && !mem_ack && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
  assign cpu_err = (state == DONE) && err_r;
`else
  logic unused_wait_limit;

  assign unused_wait_limit = (WAIT_LIMIT == 0);
  assign timeout           = 1'b0;
  assign cpu_err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_r     <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cpu_dout <= '0;
`ifdef DMEM_TIMEOUT_EN
      err_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            mem_addr <= cpu_addr;
            mem_din  <= cpu_din;
            we_r     <= cpu_we;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // ack takes priority over a coincident timeout
          if (mem_ack) begin
            if (!we_r) cpu_dout <= mem_dout;
            state <= DONE;
          end else if (timeout) begin
            if (!we_r) cpu_dout <= '0;
`ifdef DMEM_TIMEOUT_EN
            err_r <= 1'b1;
`endif
            state <= DONE;
          end
        end
        DONE: begin
`ifdef DMEM_TIMEOUT_EN
          err_r <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_cs    = (state == BUSY);
  assign mem_we    = (state == BUSY) && we_r;
  assign cpu_valid = (state == DONE);
  assign cpu_stall = ((state == IDLE) && cpu_req) || (state == BUSY);

endmodule

// File: tb/tb_dmem_requester.sv
// Randomized bench for dmem_requester: a RAM responder plus a transaction-level reference model.
// Define DMEM_TIMEOUT_EN for both bench and RTL to exercise the timeout abort.
module tb_dmem_requester;

  localparam int LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        cpu_valid;
  logic        cpu_err;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_dout;
  logic [31:0] last_addr;
  logic [31:0] last_din;

  dmem_requester #(.DATA_WIDTH(32), .WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall), .cpu_valid(cpu_valid), .cpu_err(cpu_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transaction; the RAM acks in BUSY cycle k (k beyond LIMIT means never)
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] din,
                               input int k, input bit perturb);
    int   kk;
    bit   tmo;
    int   stalls;
    logic act;
    tmo    = 1'b0;
    kk     = k;
    stalls = 0;
`ifdef DMEM_TIMEOUT_EN
    if (k > LIMIT) begin
      tmo = 1'b1;
      kk  = LIMIT;
    end
`endif
    @(negedge clk);
    #1;
    checkOutput("gap_stall", cpu_stall, 0);
    checkOutput("gap_valid", cpu_valid, 0);
    checkOutput("gap_cs", mem_cs, 0);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_din  = din;
    for (int cyc = 0; cyc <= kk + 1; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (perturb && cyc == 2) begin
        cpu_req  = 1'b0;
        cpu_addr = 32'd9;
        cpu_din  = $urandom;
      end
      mem_ack  = (cyc == k) || ((cyc == 0 || cyc == kk + 1) && $urandom_range(0, 1) == 1);
      mem_dout = (mem_addr < 32'd16) ? ram[mem_addr[3:0]] : 32'hDEAD_BEEF;
      #1;
      if (cyc == 1) begin
        last_addr = addr;
        last_din  = din;
      end
      if (cyc == kk + 1) begin
        if (!we) exp_dout = tmo ? 32'd0 : ref_mem[addr[3:0]];
        else if (!tmo) ref_mem[addr[3:0]] = din;
      end
      act = (cyc >= 1) && (cyc <= kk);
      if (cpu_stall) stalls++;
      checkOutput("stall", cpu_stall, (cyc <= kk));
      checkOutput("mem_cs", mem_cs, act);
      checkOutput("mem_we", mem_we, act && we);
      checkOutput("mem_addr", mem_addr, last_addr);
      checkOutput("mem_din", mem_din, last_din);
      checkOutput("valid", cpu_valid, (cyc == kk + 1));
      checkOutput("err", cpu_err, (cyc == kk + 1) && tmo);
      checkOutput("dout", cpu_dout, exp_dout);
      if (mem_ack && mem_cs && mem_we && mem_addr < 32'd16) ram[mem_addr[3:0]] = mem_din;
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    checkOutput("stall_total", stalls, kk + 1);
  endtask

  task automatic resetMidBusy(input logic [31:0] addr);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = addr;
    cpu_din  = $urandom;
    mem_ack  = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_pre_cs", mem_cs, 1);
    end
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_cs", mem_cs, 0);
    checkOutput("rst_valid", cpu_valid, 0);
    checkOutput("rst_stall", cpu_stall, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_din", mem_din, 0);
    checkOutput("rst_dout", cpu_dout, 0);
    rst       = 1'b0;
    exp_dout  = '0;
    last_addr = '0;
    last_din  = '0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_no_valid", cpu_valid, 0);
      checkOutput("rst_idle_cs", mem_cs, 0);
    end
  endtask

  initial begin
    int k;
    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_din  = '0;
    mem_dout = '0;
    mem_ack  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[5]     = 32'h1234_5678;
    ref_mem[5] = 32'h1234_5678;
    exp_dout   = '0;
    last_addr  = '0;
    last_din   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_dout", cpu_dout, 0);
    checkOutput("reset_stall", cpu_stall, 0);
    checkOutput("reset_valid", cpu_valid, 0);
    checkOutput("reset_err", cpu_err, 0);
    checkOutput("reset_cs", mem_cs, 0);
    checkOutput("reset_we", mem_we, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_din", mem_din, 0);
    rst = 1'b0;

    $display("[TB] directed transactions");
    applyStimulus(1'b0, 32'd5, 32'h0, 8, 1'b0);
    checkOutput("load5_data", cpu_dout, 32'h1234_5678);
    applyStimulus(1'b1, 32'd3, 32'hCAFE_F00D, 4, 1'b0);
    checkOutput("store_keeps_dout", cpu_dout, 32'h1234_5678);
    applyStimulus(1'b0, 32'd3, 32'h0, 3, 1'b0);
    checkOutput("load3_data", cpu_dout, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'd3, 32'h0, 6, 1'b1);
    checkOutput("perturb_data", cpu_dout, 32'hCAFE_F00D);
    applyStimulus(1'b1, 32'd0, 32'h5555_AAAA, 1, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'h0, 1, 1'b0);
    checkOutput("fast_load", cpu_dout, 32'h5555_AAAA);

    resetMidBusy(32'd7);

`ifdef DMEM_TIMEOUT_EN
    $display("[TB] timeout transactions");
    applyStimulus(1'b0, 32'd5, 32'h0, 1000, 1'b0);
    checkOutput("timeout_dout", cpu_dout, 0);
    applyStimulus(1'b0, 32'd5, 32'h0, LIMIT, 1'b0);
    checkOutput("ack_at_limit", cpu_dout, 32'h1234_5678);
    applyStimulus(1'b1, 32'd6, 32'h0BAD_0BAD, 1000, 1'b0);
`endif

    $display("[TB] random transactions");
    for (int t = 0; t < 30; t++) begin
      k = $urandom_range(1, 10);
`ifdef DMEM_TIMEOUT_EN
      if ($urandom_range(0, 4) == 0) k = $urandom_range(LIMIT - 1, LIMIT + 4);
`endif
      applyStimulus(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom, k,
                    ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
